// File: rtl/core_obuf_pkg.sv
`default_nettype none
// ============================================================================
// Package     : core_obuf_pkg
// Description : Shared types and constants for the core output buffer
//               (FIFO + parallel-to-serial link transmitter).
// Contents    : default geometry, beat count/width helpers, FSM state enum.
// Revision    : 1.0 - initial release
// ============================================================================
package core_obuf_pkg;

  localparam int GBUS_DATA_DEF   = 16;
  localparam int OBUF_DATA_DEF   = 64;
  localparam int OBUF_DEPTH_DEF  = 16;
  localparam int ALERT_DEPTH_DEF = 3;

  // Width of a beat index; a single-beat word still needs a 1-bit counter.
  function automatic int beat_bits(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  localparam int BEAT_NUM = OBUF_DATA_DEF / GBUS_DATA_DEF;
  localparam int BEAT_BIT = beat_bits(BEAT_NUM);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    SEND  = 2'd2
  } obuf_state_e;

endpackage
`default_nettype wire

// File: rtl/core_obuf_p2s_if.sv
`default_nettype none
// ============================================================================
// Interface   : core_obuf_p2s_if
// Description : Bundles the core write side, FIFO status and outbound
//               GBUS/clink beat handshake of the output buffer.
// Modports    : slave  - the output buffer itself
//               master - the core / link environment around it
// Revision    : 1.0 - initial release
// ============================================================================
interface core_obuf_p2s_if
  import core_obuf_pkg::*;
#(
  parameter int GBUS_DATA  = GBUS_DATA_DEF,
  parameter int OBUF_DATA  = OBUF_DATA_DEF,
  parameter int OBUF_DEPTH = OBUF_DEPTH_DEF
);
  localparam int OBUF_ADDR = $clog2(OBUF_DEPTH);

  // core write side
  logic                 obuf_wen;
  logic [OBUF_DATA-1:0] obuf_wdata;
  // FIFO status
  logic                 obuf_full;
  logic                 obuf_almost_full;
  logic                 obuf_empty;
  logic [OBUF_ADDR:0]   obuf_count;
  logic                 obuf_overflow;
  logic                 obuf_busy;
  // outbound beat channel
  logic [GBUS_DATA-1:0] gbus_wdata;
  logic                 gbus_wvalid;
  logic                 gbus_wlast;
  logic                 gbus_wready;

  modport slave (
    input  obuf_wen, obuf_wdata, gbus_wready,
    output obuf_full, obuf_almost_full, obuf_empty, obuf_count,
           obuf_overflow, obuf_busy, gbus_wdata, gbus_wvalid, gbus_wlast
  );

  modport master (
    output obuf_wen, obuf_wdata, gbus_wready,
    input  obuf_full, obuf_almost_full, obuf_empty, obuf_count,
           obuf_overflow, obuf_busy, gbus_wdata, gbus_wvalid, gbus_wlast
  );

endinterface
`default_nettype wire

// File: rtl/mem_dp_obuf.sv
`default_nettype none
// ============================================================================
// Module      : mem_dp_obuf
// Description : 1R1W memory for the output buffer FIFO. Synchronous read
//               with one cycle of latency; a read and a write to the same
//               entry in one cycle return the old contents.
// Ports       : clk          - clock
//               waddr/wen/wdata - write port
//               raddr/ren    - read request
//               rdata        - read data, valid the cycle after ren
// Revision    : 1.0 - initial release
// ============================================================================
module mem_dp_obuf
  import core_obuf_pkg::*;
#(
  parameter int OBUF_DATA  = OBUF_DATA_DEF,
  parameter int OBUF_DEPTH = OBUF_DEPTH_DEF,
  localparam int ADDR_W    = $clog2(OBUF_DEPTH)
) (
  input  logic                 clk,
  input  logic [ADDR_W-1:0]    waddr,
  input  logic                 wen,
  input  logic [OBUF_DATA-1:0] wdata,
  input  logic [ADDR_W-1:0]    raddr,
  input  logic                 ren,
  output logic [OBUF_DATA-1:0] rdata
);

  logic [OBUF_DATA-1:0] mem_q [OBUF_DEPTH];
  logic [OBUF_DATA-1:0] rdata_q;

  // Storage is deliberately unreset; the FIFO pointers define validity.
  always_ff @(posedge clk) begin
    if (wen) begin
      mem_q[waddr] <= wdata;
    end
    if (ren) begin
      rdata_q <= mem_q[raddr];
    end
  end

  assign rdata = rdata_q;

endmodule
`default_nettype wire

// File: rtl/core_obuf_p2s.sv
`default_nettype none
// ============================================================================
// Module      : core_obuf_p2s
// Description : Core output buffer. Result words written by the core are
//               queued in a FIFO and serialized, least-significant slice
//               first, into GBUS_DATA-wide beats on a valid/ready link.
// Ports       : clk   - clock
//               rstn  - asynchronous active-low reset
//               bus   - core_obuf_p2s_if.slave: core write strobe/data,
//                       FIFO status (full/almost_full/empty/count/overflow),
//                       busy flag and outbound beat handshake
// Revision    : 1.0 - initial release
// ============================================================================
module core_obuf_p2s
  import core_obuf_pkg::*;
#(
  parameter int GBUS_DATA   = GBUS_DATA_DEF,
  parameter int OBUF_DATA   = OBUF_DATA_DEF,
  parameter int OBUF_DEPTH  = OBUF_DEPTH_DEF,
  parameter int ALERT_DEPTH = ALERT_DEPTH_DEF
) (
  input  logic            clk,
  input  logic            rstn,
  core_obuf_p2s_if.slave  bus
);

  localparam int OBUF_ADDR = $clog2(OBUF_DEPTH);
  localparam int PTR_W     = OBUF_ADDR + 1;
  localparam int BEATS     = OBUF_DATA / GBUS_DATA;
  localparam int BEAT_W    = beat_bits(BEATS);

  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BEATS - 1);
  localparam logic [PTR_W-1:0]  AF_LEVEL  = PTR_W'(OBUF_DEPTH - ALERT_DEPTH);

  // --------------------------------------------------------------------------
  // State
  // --------------------------------------------------------------------------
  logic [PTR_W-1:0]     waddr_q, waddr_d;
  logic [PTR_W-1:0]     raddr_q, raddr_d;
  logic                 overflow_q, overflow_d;
  obuf_state_e          state_q, state_d;
  logic [BEAT_W-1:0]    beat_q, beat_d;
  logic [OBUF_DATA-1:0] word_q, word_d;

  logic [OBUF_DATA-1:0] mem_rdata;
  logic                 empty;
  logic                 full;
  logic [PTR_W-1:0]     count;
  logic                 ren;
  logic                 wvalid;
  logic                 wen_ok;
  logic                 beat_acc;
  logic                 last_beat;

  // --------------------------------------------------------------------------
  // FIFO pointer arithmetic: the MSB is a wrap bit that tells full from empty
  // when the low (memory index) bits coincide.
  // --------------------------------------------------------------------------
  assign empty = (waddr_q == raddr_q);
  assign full  = (waddr_q[OBUF_ADDR] != raddr_q[OBUF_ADDR]) &&
                 (waddr_q[OBUF_ADDR-1:0] == raddr_q[OBUF_ADDR-1:0]);
  assign count = waddr_q - raddr_q;

  // A write into a full FIFO still lands when the same cycle frees an entry.
  assign wen_ok    = bus.obuf_wen & (~full | ren);
  assign beat_acc  = (state_q == SEND) & bus.gbus_wready;
  assign last_beat = (beat_q == LAST_BEAT);

  // --------------------------------------------------------------------------
  // FSM: state register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // --------------------------------------------------------------------------
  // FSM: next state
  // --------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (!empty) begin
          state_d = FETCH;
        end
      end
      FETCH: begin
        state_d = SEND;
      end
      SEND: begin
        if (beat_acc && last_beat) begin
          state_d = empty ? IDLE : FETCH;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // FSM: outputs. The read for the next word is issued while the last beat
  // of the current word is accepted, so back-to-back words cost only the
  // single FETCH cycle.
  // --------------------------------------------------------------------------
  always_comb begin
    wvalid = 1'b0;
    ren    = 1'b0;
    case (state_q)
      IDLE: begin
        ren = ~empty;
      end
      SEND: begin
        wvalid = 1'b1;
        ren    = beat_acc & last_beat & ~empty;
      end
      default: begin
        wvalid = 1'b0;
        ren    = 1'b0;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // Datapath next state: pointers, overflow flag, serializer
  // --------------------------------------------------------------------------
  always_comb begin
    waddr_d    = waddr_q;
    raddr_d    = raddr_q;
    overflow_d = overflow_q;
    beat_d     = beat_q;
    word_d     = word_q;

    if (wen_ok) begin
      waddr_d = waddr_q + PTR_W'(1);
    end
    if (bus.obuf_wen && !wen_ok) begin
      overflow_d = 1'b1;
    end
    if (ren) begin
      raddr_d = raddr_q + PTR_W'(1);
    end

    // The outgoing beat is always the low slice; shifting right walks the
    // word from its least-significant slice upward.
    if (state_q == FETCH) begin
      word_d = mem_rdata;
      beat_d = '0;
    end else if (beat_acc && !last_beat) begin
      word_d = word_q >> GBUS_DATA;
      beat_d = beat_q + BEAT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      waddr_q    <= '0;
      raddr_q    <= '0;
      overflow_q <= 1'b0;
      beat_q     <= '0;
      word_q     <= '0;
    end else begin
      waddr_q    <= waddr_d;
      raddr_q    <= raddr_d;
      overflow_q <= overflow_d;
      beat_q     <= beat_d;
      word_q     <= word_d;
    end
  end

  // --------------------------------------------------------------------------
  // Storage
  // --------------------------------------------------------------------------
  mem_dp_obuf #(
    .OBUF_DATA  (OBUF_DATA),
    .OBUF_DEPTH (OBUF_DEPTH)
  ) u_mem (
    .clk   (clk),
    .waddr (waddr_q[OBUF_ADDR-1:0]),
    .wen   (wen_ok),
    .wdata (bus.obuf_wdata),
    .raddr (raddr_q[OBUF_ADDR-1:0]),
    .ren   (ren),
    .rdata (mem_rdata)
  );

  // --------------------------------------------------------------------------
  // Outputs
  // --------------------------------------------------------------------------
  assign bus.obuf_full        = full;
  assign bus.obuf_almost_full = (count >= AF_LEVEL);
  assign bus.obuf_empty       = empty;
  assign bus.obuf_count       = count;
  assign bus.obuf_overflow    = overflow_q;
  assign bus.obuf_busy        = (state_q != IDLE);
  assign bus.gbus_wvalid      = wvalid;
  assign bus.gbus_wlast       = wvalid & last_beat;
  assign bus.gbus_wdata       = wvalid ? word_q[GBUS_DATA-1:0] : '0;

endmodule
`default_nettype wire
